// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the RV32I core. Holds the program counter, issues
// one word-aligned request at a time to instruction memory, buffers the
// returned word and presents it (with its PC and pre-sliced decode fields) to
// the control decoder. Redirects from execute squash in-flight work.
//
// Ports
//   clk, rst                      core clock, synchronous active-high reset
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_rsp_valid/data           response channel (valid only, no ready)
//   redirect_valid/pc             one-cycle branch/jump redirect from execute
//   instr_valid/ready             handshake to decode
//   instr, instr_pc               buffered instruction word and its PC
//   opcode, funct3, funct7        slices of instr
//   fetch_fault                   sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,

    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,

    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StFault
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        squash_q;
    logic        fetch_fault_q;

    logic        req_fire;
    logic        redirect_misaligned;

    assign req_fire            = (state_q == StReq) && imem_req_ready;
    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            squash_q      <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else if (state_q == StFault) begin
            // Terminal until reset; swallow the response of any request that
            // was still outstanding when the fault was taken.
            if (imem_rsp_valid) begin
                squash_q <= 1'b0;
            end
        end else if (redirect_valid && redirect_misaligned) begin
            fetch_fault_q <= 1'b1;
            state_q       <= StFault;
            squash_q      <= req_fire || ((state_q == StWait) && !imem_rsp_valid);
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
            case (state_q)
                StReq: begin
                    // An accepted request carries the old pc: mark it stale.
                    if (imem_req_ready) begin
                        state_q  <= StWait;
                        squash_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        state_q  <= StReq;
                        squash_q <= 1'b0;
                    end else begin
                        squash_q <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and HOLD: restart fetching at the new pc.
                    state_q <= StReq;
                end
            endcase
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StReq;
                end
                StReq: begin
                    if (imem_req_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        if (squash_q) begin
                            squash_q <= 1'b0;
                            state_q  <= StReq;
                        end else begin
                            instr_q    <= imem_rsp_data;
                            instr_pc_q <= pc_q;
                            state_q    <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= StReq;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode from registered state only.
    assign imem_req_valid = (state_q == StReq);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == StHold);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign opcode         = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7         = instr_q[31:25];
    assign fetch_fault    = fetch_fault_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of the control decoder. It holds the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready request channel with a valid-only response channel. It buffers the returned word and presents it, with its PC and the pre-sliced opcode/funct3/funct7 fields, to the decode/control stage over a valid/ready handshake. Branch/jump redirects from the execute stage squash in-flight work and restart fetching.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word-aligned.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  byte address of requested word, always [1:0]=0
- imem_rsp_valid  in  1  response word valid; at most one per accepted request, no earlier than the cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse, take new PC
- redirect_pc  in  32  redirect target
- instr_valid  out  1  instruction presented to decode
- instr_ready  in  1  decode consumes instruction
- instr  out  32  buffered instruction word
- instr_pc  out  32  PC of instr
- opcode  out  7  instr[6:0]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- fetch_fault  out  1  sticky misaligned-redirect flag

## Operation
- Registers: pc (32), state, squash (1), instr, instr_pc, fetch_fault.
- States: IDLE, REQ, WAIT, HOLD, FAULT. One request outstanding maximum.
- IDLE: entered on rst; unconditionally -> REQ next cycle.
- REQ: imem_req_valid=1, imem_req_addr=pc. On req_valid&&req_ready -> WAIT.
- WAIT: on imem_rsp_valid with squash=0: instr<=rsp_data, instr_pc<=pc, -> HOLD. With squash=1: drop word, clear squash, -> REQ.
- HOLD: instr_valid=1. On instr_ready: pc<=pc+4, -> REQ.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC+4 = 0, no fault.
- Redirect (highest priority), aligned target: pc<=redirect_pc, then per state:
  - REQ without acceptance: stay REQ; the new address drives the next cycle.
  - REQ with acceptance: the accepted old request is stale; -> WAIT, squash<=1.
  - WAIT without rsp: squash<=1.
  - WAIT with rsp same cycle: drop the word, -> REQ.
  - HOLD: drop buffered word, -> REQ. If instr_ready is also high, that transfer still completes; pc comes from redirect, not +4.
  - IDLE: pc<=redirect_pc, -> REQ.
- Misaligned redirect (redirect_pc[1:0]!=0): fetch_fault<=1, -> FAULT. pc is not updated.
  - If a request is outstanding, its response is absorbed and dropped.
  - FAULT issues no further requests; exit only via rst.
- imem_rsp_valid outside WAIT is a protocol error: ignored, flagged by a bench assertion.
- opcode/funct3/funct7 are pure slices of the instr register.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, squash=0, instr=0, instr_pc=0, fetch_fault=0.
- Outputs while rst high: imem_req_valid=0, instr_valid=0.
- imem_req_valid, imem_req_addr and instr_valid decode from registered state only. There is no combinational path from any input to any output.
- Cycle numbering: cycle 0 is the first cycle with rst low.
  - cycle 0: IDLE.
  - cycle 1: request for RESET_PC.
  - Zero-wait memory: accept in cycle 1, rsp in cycle 2, instr_valid in cycle 3.
  - instr_ready in cycle 3 gives the next request in cycle 4.
- Steady-state throughput: one instruction per 3 cycles with an ideal memory and an always-ready decoder.
- Redirect-to-request latency: 1 cycle from REQ/HOLD/IDLE. From WAIT it waits for the stale response.
- rst asserted mid-operation: all state returns to reset values next edge; any pending response is ignored after reset.

## Test plan
- Reset, req_ready=1, memory returns 32'h0000_0033 one cycle after accept -> addresses 0,4,8 are requested in cycles 1,4,7. instr=32'h33, opcode=7'h33, instr_pc=0 in cycle 3.
- Decoder back-pressure: instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr and instr_pc stable; no new request issued.
- Redirect to 32'h100 during WAIT, response 3 cycles later -> stale word is never presented; the next request is 32'h100 and instr_pc=32'h100.
- Redirect to 32'h200 in the same cycle as rsp_valid in WAIT -> word dropped, request 32'h200 the next cycle. Redirect together with an accepted request in REQ -> that response is squashed.
- Start at RESET_PC=32'hFFFF_FFFC -> after one instruction the next request address is 32'h0000_0000 and fetch_fault=0.
- Redirect to 32'h102 -> fetch_fault=1 next cycle and no further requests. Then rst for 1 cycle -> fetch_fault=0 and a request for RESET_PC in cycle 1.
